fir_decim_mc: RTL
=================

# fir_decim_mc

Multi-channel, fully parametrised decimating FIR filter for the FM receive chain. It consumes one multi-channel sample word per FIFO pop, for example packed I/Q after demodulation. Every DECIMATION pops it computes one TAPS-long dot product per channel, running all channels in parallel, and pushes one packed output word. Fixed-point quantisation is parametrised (QUANT_BITS), and output saturation is optional.

## Interface
- DATA_WIDTH, 32: sample and coefficient width per channel, signed.
- CHANNELS, 2: number of parallel channels. Channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- TAPS, 32: filter length, 1 or more.
- DECIMATION, 8: input pops per output, 1 or more. DECIMATION ≤ TAPS.
- QUANT_BITS, 10: fractional bits of the coefficients. Each product is arithmetically shifted right by this amount.
- COEFF, [0:TAPS-1][DATA_WIDTH-1:0]: default is the team's 32-tap channel-select low-pass. Values: k0=-1, k3=2, k7=12, k15=-138, k23=8, k31=-1; symmetric; sum -882.
- clock  in  1  the single clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- x_in  in  CHANNELS*DATA_WIDTH  packed input samples from a first-word-fall-through FIFO.
- x_in_rd_en  out  1  pop strobe.
- x_in_empty  in  1  input FIFO empty.
- y_out  out  CHANNELS*DATA_WIDTH  packed filtered output.
- y_out_wr_en  out  1  push strobe.
- y_out_full  in  1  output FIFO full.

## Operation
- Delay line: x[0:TAPS-1] per channel, where x[0] is the newest sample. Each pop shifts x[i] ← x[i-1] and loads x[0] ← x_in.
- Filter equation, per channel: y = Σk COEFF[k]·x[k].
- Product: signed 2·DATA_WIDTH bits, then >>> QUANT_BITS, then truncated to DATA_WIDTH.
- Accumulator: DATA_WIDTH + clog2(TAPS) bits, signed. It is cleared at the start of each COMPUTE.
- Output narrowing: without saturation, the low DATA_WIDTH bits are taken (two's-complement wrap).
- FSM states: FILL, COMPUTE, WRITE. The reset state is FILL, with the pop counter at 0.
- FILL:
  - x_in_rd_en = !x_in_empty, combinational.
  - Each cycle with a pop shifts the delay line and increments the counter.
  - After the DECIMATION-th pop, go to COMPUTE with tap index 0.
  - Empty cycles stall, with no state change.
- COMPUTE:
  - One tap per cycle, all channels in parallel. The tap index runs 0..TAPS-1.
  - After tap TAPS-1 is accumulated, go to WRITE.
  - The input is never popped in this state.
- WRITE:
  - y_out_wr_en = !y_out_full, combinational.
  - On the push cycle, go to FILL.
  - While full, hold the state and keep y_out stable.
- y_out is registered. It is loaded with the narrowed accumulator on entry to WRITE and holds that value until the next WRITE.
- History: the delay line is zero at reset and is never cleared between outputs. The first outputs are the filter's response primed with zeros.

## Timing
- Reset values:
  - x_in_rd_en = 0, y_out_wr_en = 0, y_out = 0.
  - Delay line and accumulator are 0; state is FILL.
- Reset has priority over all other activity. Reset asserted in any state, including mid-COMPUTE or during a WRITE stall, aborts the work in progress: the partial result is discarded and nothing is pushed.
- Minimum period per output, with no stalls: DECIMATION (FILL) + TAPS (COMPUTE) + 1 (WRITE) cycles. This is 41 cycles at the defaults.
- Latency: y_out_wr_en rises TAPS+1 cycles after the cycle of the DECIMATION-th pop.
- x_in_rd_en and y_out_wr_en are never high in the same cycle. Neither is ever asserted while its FIFO's empty or full flag is high.
- DECIMATION=1: one pop, then COMPUTE. TAPS=1: COMPUTE lasts one cycle.

## Configuration
- FIR_SAT_EN defined: each channel's accumulator is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before being loaded into y_out.
- FIR_SAT_EN undefined: the low DATA_WIDTH bits are taken (wrap), and no clamp logic is built.
- Cycle timing is identical in both builds.

## Test plan
- Impulse, default parameters:
  - Stimulus: ch0 = 1024 on the first pop, then 0; ch1 = 0 throughout.
  - Required: ch0 outputs 12, -138, 8, -1, then 0 thereafter; ch1 outputs all 0.
- DC, default parameters:
  - Stimulus: 1024 on both channels, continuously.
  - Required: from output 4 onward, both channels equal -882 (0xFFFFFC8E).
- Throughput and latency:
  - Stimulus: FIFO never empty, output never full.
  - Required: one push every 41 cycles; pops occur in bursts of exactly 8 consecutive cycles.
- Back-pressure and starvation:
  - Stimulus: hold y_out_full for 10 cycles while in WRITE; leave 3-cycle empty gaps during FILL.
  - Required: no push and no pop during the stall; y_out stable; the result stream is identical to the unstalled run.
- Saturation:
  - Parameters: DATA_WIDTH=16, TAPS=4, DECIMATION=1, COEFF all 1024.
  - Stimulus: input 0x7FFF, continuously.
  - Required: the 4th output onward is 0x7FFF with FIR_SAT_EN defined, and 0xFFFC without it.
- Reset mid-COMPUTE:
  - Stimulus: assert reset for 1 cycle during tap 10, then replay the impulse test.
  - Required: all outputs are 0 during reset; the following outputs exactly match the impulse sequence, so no history survives the reset.

Source files
------------

// File: rtl/fir_decim_mc.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_mc
// Description : Multi-channel decimating FIR filter. It pops one packed
//               multi-channel word per cycle from a first-word-fall-through
//               FIFO. After DECIMATION pops it evaluates one TAPS-long dot
//               product per channel, one tap per cycle with all channels in
//               parallel, and pushes one packed result word to the output
//               FIFO.
//               Each product is arithmetically shifted right by QUANT_BITS
//               and truncated to DATA_WIDTH.
//               Optional macro FIR_SAT_EN: when defined, each channel's
//               accumulator is clamped to the DATA_WIDTH signed range before
//               it is loaded into y_out. When undefined, the low bits are
//               taken and the result wraps.
// Ports       : clock        rising-edge clock
//               reset        synchronous active-high reset
//               x_in         packed input samples (channel c at c*DATA_WIDTH)
//               x_in_rd_en   input FIFO pop strobe
//               x_in_empty   input FIFO empty flag
//               y_out        packed registered filter output
//               y_out_wr_en  output FIFO push strobe
//               y_out_full   output FIFO full flag
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int TAPS       = 32,
    parameter int DECIMATION = 8,
    parameter int QUANT_BITS = 10,
    // Default: 32-tap symmetric channel-select low-pass, coefficient sum -882
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF = {
        DATA_WIDTH'(-1),   DATA_WIDTH'(-2),   DATA_WIDTH'(-1),   DATA_WIDTH'(2),
        DATA_WIDTH'(3),    DATA_WIDTH'(4),    DATA_WIDTH'(8),    DATA_WIDTH'(12),
        DATA_WIDTH'(8),    DATA_WIDTH'(-3),   DATA_WIDTH'(-20),  DATA_WIDTH'(-45),
        DATA_WIDTH'(-70),  DATA_WIDTH'(-90),  DATA_WIDTH'(-108), DATA_WIDTH'(-138),
        DATA_WIDTH'(-138), DATA_WIDTH'(-108), DATA_WIDTH'(-90),  DATA_WIDTH'(-70),
        DATA_WIDTH'(-45),  DATA_WIDTH'(-20),  DATA_WIDTH'(-3),   DATA_WIDTH'(8),
        DATA_WIDTH'(12),   DATA_WIDTH'(8),    DATA_WIDTH'(4),    DATA_WIDTH'(3),
        DATA_WIDTH'(2),    DATA_WIDTH'(-1),   DATA_WIDTH'(-2),   DATA_WIDTH'(-1)
    }
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
    output logic                           x_in_rd_en,
    input  logic                           x_in_empty,
    output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
    output logic                           y_out_wr_en,
    input  logic                           y_out_full
);

    localparam int c_ACC_W = DATA_WIDTH + $clog2(TAPS);
    localparam int c_TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int c_CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    localparam logic [1:0] c_ST_FILL    = 2'd0;
    localparam logic [1:0] c_ST_COMPUTE = 2'd1;
    localparam logic [1:0] c_ST_WRITE   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TAP_W-1:0] r_tap_idx;

    logic w_pop;
    logic w_push;
    logic w_start;
    logic w_computing;
    logic w_last_tap;

    // Strobes are gated by reset so nothing moves in or out while it is held.
    assign w_pop       = !reset && (r_state == c_ST_FILL) && !x_in_empty;
    assign w_push      = !reset && (r_state == c_ST_WRITE) && !y_out_full;
    assign w_start     = w_pop && (r_cnt == c_CNT_W'(DECIMATION - 1));
    assign w_computing = (r_state == c_ST_COMPUTE);
    assign w_last_tap  = (r_tap_idx == c_TAP_W'(TAPS - 1));

    assign x_in_rd_en  = w_pop;
    assign y_out_wr_en = w_push;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_ST_FILL;
            r_cnt     <= '0;
            r_tap_idx <= '0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_pop) begin
                        if (w_start) begin
                            r_cnt     <= '0;
                            r_tap_idx <= '0;
                            r_state   <= c_ST_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    if (w_last_tap) begin
                        r_state <= c_ST_WRITE;
                    end else begin
                        r_tap_idx <= r_tap_idx + 1'b1;
                    end
                end
                c_ST_WRITE: begin
                    if (w_push) begin
                        r_state <= c_ST_FILL;
                    end
                end
                default: begin
                    r_state <= c_ST_FILL;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [DATA_WIDTH-1:0]          r_line [TAPS];
        logic signed [c_ACC_W-1:0]      r_acc;
        logic [DATA_WIDTH-1:0]          r_y;
        logic signed [DATA_WIDTH-1:0]   w_sample;
        logic signed [DATA_WIDTH-1:0]   w_coeff;
        logic signed [2*DATA_WIDTH-1:0] w_sample_ext;
        logic signed [2*DATA_WIDTH-1:0] w_coeff_ext;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic signed [DATA_WIDTH-1:0]   w_prod_q;
        logic signed [c_ACC_W-1:0]      w_acc_next;
        logic [DATA_WIDTH-1:0]          w_narrow;

        assign w_sample     = r_line[r_tap_idx];
        assign w_coeff      = COEFF[r_tap_idx];
        assign w_sample_ext = {{DATA_WIDTH{w_sample[DATA_WIDTH-1]}}, w_sample};
        assign w_coeff_ext  = {{DATA_WIDTH{w_coeff[DATA_WIDTH-1]}}, w_coeff};
        assign w_prod       = w_sample_ext * w_coeff_ext;
        // Quantise the full-width product, then keep only DATA_WIDTH bits.
        assign w_prod_q     = DATA_WIDTH'(w_prod >>> QUANT_BITS);
        assign w_acc_next   = r_acc + c_ACC_W'(w_prod_q);

`ifdef FIR_SAT_EN
        // The value fits when every bit from the sign position upward agrees.
        logic [c_ACC_W-DATA_WIDTH:0] w_hi;
        assign w_hi = w_acc_next[c_ACC_W-1:DATA_WIDTH-1];

        always_comb begin
            if ((w_hi == '0) || (w_hi == '1)) begin
                w_narrow = w_acc_next[DATA_WIDTH-1:0];
            end else if (w_acc_next[c_ACC_W-1]) begin
                w_narrow = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                w_narrow = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
`else
        assign w_narrow = w_acc_next[DATA_WIDTH-1:0];
`endif

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < TAPS; i++) begin
                    r_line[i] <= '0;
                end
                r_acc <= '0;
                r_y   <= '0;
            end else begin
                if (w_pop) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        r_line[i] <= r_line[i-1];
                    end
                    r_line[0] <= x_in[c*DATA_WIDTH +: DATA_WIDTH];
                end
                // The pop that completes a decimation group also clears the
                // accumulator, so COMPUTE always starts from zero.
                if (w_start) begin
                    r_acc <= '0;
                end else if (w_computing) begin
                    r_acc <= w_acc_next;
                end
                // The final tap's sum goes straight into y_out, which then
                // holds through any WRITE stall.
                if (w_computing && w_last_tap) begin
                    r_y <= w_narrow;
                end
            end
        end

        assign y_out[c*DATA_WIDTH +: DATA_WIDTH] = r_y;
    end

endmodule
`default_nettype wire
